// File: rtl/rv_tapped_shift_register.sv
// Multi-lane delay line with per-stage valid bits, a runtime-selectable output tap,
// synchronous flush and a registered occupancy counter.
module rv_tapped_shift_register #(
    parameter int DATAW  = 8,
    parameter int LANES  = 2,
    parameter int DEPTH  = 4,
    parameter int DEPTHW = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     enable,
    input  logic                     flush,
    input  logic                     valid_in,
    input  logic [LANES*DATAW-1:0]   data_in,
    input  logic [DEPTHW-1:0]        tap_sel,
    output logic                     valid_out,
    output logic [LANES*DATAW-1:0]   data_out,
    output logic [DEPTHW:0]          count,
    output logic                     full,
    output logic                     empty
);

    localparam int BW   = LANES * DATAW;
    localparam int CNTW = DEPTHW + 1;

    // valid_in/data_in are only sampled on a cycle with enable=1 and flush=0;
    // there is no back-pressure, the stage at DEPTH-1 simply falls off the end.
    logic [DEPTH-1:0] valid_q;
    logic [BW-1:0]    data_q [DEPTH];
    logic [CNTW-1:0]  count_q;
    logic [DEPTHW-1:0] tap_idx;

    always_ff @(posedge clk) begin
        if (reset || flush) begin
            valid_q <= '0;
            count_q <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                data_q[i] <= '0;
            end
        end else if (enable) begin
            valid_q[0] <= valid_in;
            data_q[0]  <= data_in;
            for (int i = 1; i < DEPTH; i++) begin
                valid_q[i] <= valid_q[i-1];
                data_q[i]  <= data_q[i-1];
            end
            // Entry and exit in the same advance cancel out.
            count_q <= count_q + CNTW'(valid_in) - CNTW'(valid_q[DEPTH-1]);
        end
    end

    always_comb begin
        tap_idx = tap_sel;
        if (32'(tap_sel) >= DEPTH) begin
            tap_idx = DEPTHW'(DEPTH - 1);
        end
    end

    always_comb begin
        valid_out = valid_q[tap_idx];
        data_out  = data_q[tap_idx];
    end

    assign count = count_q;
    assign full  = (count_q == CNTW'(DEPTH));
    assign empty = (count_q == '0);

endmodule

// File: tb/tb_rv_tapped_shift_register.sv
// Directed and randomised checks of rv_tapped_shift_register at DATAW=8, LANES=2, DEPTH=4.
module tb_rv_tapped_shift_register;

    localparam int DATAW  = 8;
    localparam int LANES  = 2;
    localparam int DEPTH  = 4;
    localparam int DEPTHW = 2;
    localparam int BW     = LANES * DATAW;

    logic              clk = 1'b0;
    logic              reset = 1'b1;
    logic              enable = 1'b0;
    logic              flush = 1'b0;
    logic              valid_in = 1'b0;
    logic [BW-1:0]     data_in = '0;
    logic [DEPTHW-1:0] tap_sel = '0;
    logic              valid_out;
    logic [BW-1:0]     data_out;
    logic [DEPTHW:0]   count;
    logic              full;
    logic              empty;

    int total = 0;
    int bad   = 0;

    rv_tapped_shift_register #(
        .DATAW(DATAW), .LANES(LANES), .DEPTH(DEPTH), .DEPTHW(DEPTHW)
    ) dut (
        .clk(clk), .reset(reset), .enable(enable), .flush(flush),
        .valid_in(valid_in), .data_in(data_in), .tap_sel(tap_sel),
        .valid_out(valid_out), .data_out(data_out), .count(count),
        .full(full), .empty(empty)
    );

    always #5 clk = ~clk;

    // Inputs change 1 time unit after the rising edge; outputs are sampled there too.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic v, input logic [BW-1:0] d);
        enable = 1'b1; valid_in = v; data_in = d;
        tick();
        enable = 1'b0; valid_in = 1'b0; data_in = '0;
    endtask

    task automatic test_reset();
        reset = 1'b1; enable = 1'b1; valid_in = 1'b1; data_in = 16'hFFFF;
        tick();
        tick();
        for (int t = 0; t < DEPTH; t++) begin
            tap_sel = DEPTHW'(t);
            #1;
            total++;
            if (count !== 3'd0) begin bad++; $display("FAIL reset_count tap=%0d got=%0d exp=0", t, count); end
            total++;
            if (empty !== 1'b1) begin bad++; $display("FAIL reset_empty tap=%0d got=%b exp=1", t, empty); end
            total++;
            if (full !== 1'b0) begin bad++; $display("FAIL reset_full tap=%0d got=%b exp=0", t, full); end
            total++;
            if (valid_out !== 1'b0) begin bad++; $display("FAIL reset_valid tap=%0d got=%b exp=0", t, valid_out); end
            total++;
            if (data_out !== 16'h0000) begin bad++; $display("FAIL reset_data tap=%0d got=%h exp=0000", t, data_out); end
        end
        reset = 1'b0; enable = 1'b0; valid_in = 1'b0; data_in = '0;
        tick();
    endtask

    task automatic test_latency();
        logic          exp_v;
        logic [BW-1:0] exp_d;
        tap_sel = 2'd3;
        for (int n = 1; n <= 5; n++) begin
            if (n == 1) push(1'b1, {8'hA1, 8'hB2});
            else        push(1'b0, 16'h0000);
            exp_v = (n == 4);
            exp_d = (n == 4) ? 16'hA1B2 : 16'h0000;
            total++;
            if (valid_out !== exp_v) begin bad++; $display("FAIL latency_valid adv=%0d got=%b exp=%b", n, valid_out, exp_v); end
            total++;
            if (data_out !== exp_d) begin bad++; $display("FAIL latency_data adv=%0d got=%h exp=%h", n, data_out, exp_d); end
        end
    endtask

    task automatic test_runtime_tap();
        logic [BW-1:0] exp_d [5] = '{16'd4, 16'd3, 16'd2, 16'd1, 16'd1};
        logic [DEPTHW-1:0] taps [5] = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd3}; // last entry: 7 truncated to the 2-bit port
        flush = 1'b1; tick(); flush = 1'b0;
        for (int k = 1; k <= 4; k++) push(1'b1, BW'(k));
        for (int k = 0; k < 5; k++) begin
            tap_sel = taps[k];
            #1;
            total++;
            if (data_out !== exp_d[k]) begin bad++; $display("FAIL tap_data sel=%0d got=%h exp=%h", taps[k], data_out, exp_d[k]); end
            total++;
            if (valid_out !== 1'b1) begin bad++; $display("FAIL tap_valid sel=%0d got=%b exp=1", taps[k], valid_out); end
            total++;
            if (count !== 3'd4 || full !== 1'b1) begin bad++; $display("FAIL tap_count sel=%0d got=%0d/%b exp=4/1", taps[k], count, full); end
            tick();
        end
    endtask

    task automatic test_stall();
        tap_sel = 2'd3;
        for (int k = 0; k < 4; k++) begin
            push(1'b1, BW'(5 + k));
            total++;
            if (data_out !== BW'(2 + k)) begin bad++; $display("FAIL stall_adv_data k=%0d got=%h exp=%h", k, data_out, BW'(2 + k)); end
            total++;
            if (count !== 3'd4 || full !== 1'b1) begin bad++; $display("FAIL stall_adv_count k=%0d got=%0d/%b exp=4/1", k, count, full); end
            enable = 1'b0; valid_in = 1'b1; data_in = 16'hEEEE;
            tick();
            valid_in = 1'b0; data_in = '0;
            total++;
            if (data_out !== BW'(2 + k)) begin bad++; $display("FAIL stall_hold_data k=%0d got=%h exp=%h", k, data_out, BW'(2 + k)); end
            total++;
            if (count !== 3'd4 || full !== 1'b1) begin bad++; $display("FAIL stall_hold_count k=%0d got=%0d/%b exp=4/1", k, count, full); end
        end
    endtask

    task automatic test_flush();
        flush = 1'b1; enable = 1'b1; valid_in = 1'b1; data_in = 16'h9999;
        tick();
        flush = 1'b0; enable = 1'b0; valid_in = 1'b0; data_in = '0;
        total++;
        if (count !== 3'd0 || empty !== 1'b1 || full !== 1'b0) begin
            bad++; $display("FAIL flush_status got=%0d/%b/%b exp=0/1/0", count, empty, full);
        end
        for (int t = 0; t < DEPTH; t++) begin
            tap_sel = DEPTHW'(t);
            #1;
            total++;
            if (valid_out !== 1'b0 || data_out !== 16'h0000) begin
                bad++; $display("FAIL flush_tap tap=%0d got=%b/%h exp=0/0000", t, valid_out, data_out);
            end
        end
    endtask

    task automatic test_random();
        logic          m_v [DEPTH];
        logic [BW-1:0] m_d [DEPTH];
        int            pop;
        reset = 1'b1; tick(); reset = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin m_v[i] = 1'b0; m_d[i] = '0; end
        for (int c = 0; c < 10000; c++) begin
            reset    = ($urandom_range(0, 63) == 0);
            flush    = ($urandom_range(0, 15) == 0);
            enable   = $urandom_range(0, 1) == 1;
            valid_in = $urandom_range(0, 1) == 1;
            data_in  = BW'($urandom_range(0, 65535));
            tap_sel  = DEPTHW'($urandom_range(0, DEPTH - 1));
            #1;
            pop = 0;
            for (int i = 0; i < DEPTH; i++) pop += int'(m_v[i]);
            total++;
            if (valid_out !== m_v[tap_sel] || data_out !== m_d[tap_sel]) begin
                bad++; $display("FAIL rand_tap cyc=%0d tap=%0d got=%b/%h exp=%b/%h", c, tap_sel, valid_out, data_out, m_v[tap_sel], m_d[tap_sel]);
            end
            total++;
            if (int'(count) !== pop || full !== (pop == DEPTH) || empty !== (pop == 0)) begin
                bad++; $display("FAIL rand_count cyc=%0d got=%0d/%b/%b exp=%0d", c, count, full, empty, pop);
            end
            if (reset || flush) begin
                for (int i = 0; i < DEPTH; i++) begin m_v[i] = 1'b0; m_d[i] = '0; end
            end else if (enable) begin
                for (int i = DEPTH - 1; i > 0; i--) begin m_v[i] = m_v[i-1]; m_d[i] = m_d[i-1]; end
                m_v[0] = valid_in; m_d[0] = data_in;
            end
            @(posedge clk);
            #1;
        end
        reset = 1'b0; flush = 1'b0; enable = 1'b0; valid_in = 1'b0;
    endtask

    initial begin
        #1;
        test_reset();
        test_latency();
        test_runtime_tap();
        test_stall();
        test_flush();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
